matmul_sequencer: RTL and testbench

Control sequencer for the matrix-multiply datapath. It reads the size header and operands of A (M×K) and B (K×N) from the dual-port data RAM, streams operand pairs to the external multiply-accumulate unit over a valid/ready handshake, and writes each finished C element back to RAM. It sits between the RAM ports and the MAC unit, and is started by the top-level controller.

---
 rtl/matmul_pkg.sv | 27 ++
 rtl/matmul_addr_gen.sv | 94 +++++++++
 rtl/matmul_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_matmul_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and constants for the matrix-multiply sequencer.
// Holds the FSM state encoding, header field layout, size limits and A base.
package matmul_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    CHECK,
    ISSUE,
    FETCH,
    SEND,
    WAIT_RES,
    WRITE,
    DONE
  } state_t;

  // header word: M in [7:0], K in [15:8], N in [23:16]
  localparam int DIM_W     = 8;
  localparam int MAX_LEN   = 100;
  localparam int HDR_M_LSB = 0;
  localparam int HDR_K_LSB = 8;
  localparam int HDR_N_LSB = 16;

  // A starts right after the header word
  localparam int A_BASE = 1;

endpackage

// File: rtl/matmul_addr_gen.sv
// matmul_addr_gen: row/col/idx pointers and the A, B and C RAM addresses.
// Ports: clear loads bases, step_idx advances one pair, step_elem one C
// element; addr_op_a/addr_op_b/addr_c, last_idx and last_elem are outputs.
module matmul_addr_gen
  import matmul_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  step_idx,
  input  logic                  step_elem,
  input  logic [CNT_W-1:0]      m,
  input  logic [CNT_W-1:0]      k,
  input  logic [CNT_W-1:0]      n,
  input  logic [ADDR_WIDTH-1:0] b_base,
  input  logic [ADDR_WIDTH-1:0] c_base,
  output logic [ADDR_WIDTH-1:0] addr_op_a,
  output logic [ADDR_WIDTH-1:0] addr_op_b,
  output logic [ADDR_WIDTH-1:0] addr_c,
  output logic                  last_idx,
  output logic                  last_elem
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0]      row;
  logic [CNT_W-1:0]      col;
  logic [CNT_W-1:0]      idx;
  logic [ADDR_WIDTH-1:0] a_row;
  logic [ADDR_WIDTH-1:0] a_ptr;
  logic [ADDR_WIDTH-1:0] b_ptr;
  logic [ADDR_WIDTH-1:0] b_base_q;
  logic [ADDR_WIDTH-1:0] c_ptr;
  logic [ADDR_WIDTH-1:0] k_w;
  logic [ADDR_WIDTH-1:0] n_w;
  logic                  col_wrap;

  assign k_w      = ADDR_WIDTH'(k);
  assign n_w      = ADDR_WIDTH'(n);
  assign col_wrap = (col == n - ONE);

  assign last_idx  = (idx == k - ONE);
  assign last_elem = (row == m - ONE) && col_wrap;

  assign addr_op_a = a_ptr;
  assign addr_op_b = b_ptr;
  assign addr_c    = c_ptr;

  // a_row tracks 1+row*K so a new row never needs a multiply
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row      <= '0;
      col      <= '0;
      idx      <= '0;
      a_row    <= '0;
      a_ptr    <= '0;
      b_ptr    <= '0;
      b_base_q <= '0;
      c_ptr    <= '0;
    end else if (clear) begin
      row      <= '0;
      col      <= '0;
      idx      <= '0;
      a_row    <= ADDR_WIDTH'(A_BASE);
      a_ptr    <= ADDR_WIDTH'(A_BASE);
      b_ptr    <= b_base;
      b_base_q <= b_base;
      c_ptr    <= c_base;
    end else if (step_idx) begin
      idx   <= idx + ONE;
      a_ptr <= a_ptr + ADDR_WIDTH'(1);
      b_ptr <= b_ptr + n_w;
    end else if (step_elem) begin
      idx   <= '0;
      c_ptr <= c_ptr + ADDR_WIDTH'(1);
      if (col_wrap) begin
        col   <= '0;
        row   <= row + ONE;
        a_row <= a_row + k_w;
        a_ptr <= a_row + k_w;
        b_ptr <= b_base_q;
      end else begin
        col   <= col + ONE;
        a_ptr <= a_row;
        b_ptr <= b_base_q + ADDR_WIDTH'(col)
                 + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: reads header/operands from RAM, feeds the MAC unit and
// writes C back. Ports: start/busy/done/size_err control, RAM ports A/B
// (addr, we, din, dout_a), MAC operand handshake and result input.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_LEN    = matmul_pkg::MAX_LEN,
  parameter int DIM_W      = matmul_pkg::DIM_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  size_err,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic                  we_a,
  output logic                  we_b,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  output logic                  mac_valid,
  output logic                  mac_last,
  input  logic                  mac_ready,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data
);

  localparam int PW = 2 * DIM_W;
  localparam logic [DIM_W-1:0] LEN_MAX = DIM_W'(MAX_LEN);
  localparam logic [31:0] ADDR_TOP =
    32'((64'd1 << ADDR_WIDTH) - 64'd1);

  state_t state_q;
  state_t state_d;

  logic [DIM_W-1:0]      m_q;
  logic [DIM_W-1:0]      k_q;
  logic [DIM_W-1:0]      n_q;
  logic [PW-1:0]         mk_q;
  logic [PW-1:0]         kn_q;
  logic [PW-1:0]         mn_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic [DATA_WIDTH-1:0] mac_a_q;
  logic [DATA_WIDTH-1:0] mac_b_q;
  logic                  size_err_q;

  logic [DIM_W-1:0]      hdr_m;
  logic [DIM_W-1:0]      hdr_k;
  logic [DIM_W-1:0]      hdr_n;
  logic [31:0]           c_end;
  logic                  hdr_bad;
  logic [ADDR_WIDTH-1:0] b_base_c;
  logic [ADDR_WIDTH-1:0] c_base_c;

  logic                  clear;
  logic                  step_idx;
  logic                  step_elem;
  logic                  err_set;
  logic [ADDR_WIDTH-1:0] op_a;
  logic [ADDR_WIDTH-1:0] op_b;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic                  last_idx;
  logic                  last_elem;

  assign hdr_m = din_a[HDR_M_LSB +: DIM_W];
  assign hdr_k = din_a[HDR_K_LSB +: DIM_W];
  assign hdr_n = din_a[HDR_N_LSB +: DIM_W];

  // last C address is C_BASE+M*N-1 = M*K + K*N + M*N
  assign c_end = 32'(mk_q) + 32'(kn_q) + 32'(mn_q);

  assign hdr_bad = (m_q == '0) || (k_q == '0) ||
                   (n_q == '0) || (m_q > LEN_MAX) ||
                   (k_q > LEN_MAX) || (n_q > LEN_MAX) ||
                   (c_end > ADDR_TOP);

  assign b_base_c = ADDR_WIDTH'(A_BASE + 32'(mk_q));
  assign c_base_c = ADDR_WIDTH'(A_BASE + 32'(mk_q)
                                + 32'(kn_q));

  matmul_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_W      (DIM_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .step_idx  (step_idx),
    .step_elem (step_elem),
    .m         (m_q),
    .k         (k_q),
    .n         (n_q),
    .b_base    (b_base_c),
    .c_base    (c_base_c),
    .addr_op_a (op_a),
    .addr_op_b (op_b),
    .addr_c    (c_addr),
    .last_idx  (last_idx),
    .last_elem (last_elem)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_a    = '0;
    addr_b    = '0;
    we_a      = 1'b0;
    dout_a    = '0;
    clear     = 1'b0;
    step_idx  = 1'b0;
    step_elem = 1'b0;
    err_set   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = HDR;
      end
      HDR: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (hdr_bad) begin
          err_set = 1'b1;
          state_d = DONE;
        end else begin
          clear   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        addr_a  = op_a;
        addr_b  = op_b;
        state_d = FETCH;
      end
      FETCH: begin
        addr_a  = op_a;
        addr_b  = op_b;
        state_d = SEND;
      end
      SEND: begin
        addr_a = op_a;
        addr_b = op_b;
        if (mac_ready) begin
          if (last_idx) begin
            state_d = WAIT_RES;
          end else begin
            step_idx = 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      WAIT_RES: begin
        if (res_valid) state_d = WRITE;
      end
      WRITE: begin
        addr_a    = c_addr;
        we_a      = 1'b1;
        dout_a    = res_q;
        step_elem = 1'b1;
        state_d   = last_elem ? DONE : ISSUE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // products come straight from the header read so CHECK sees them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q        <= '0;
      k_q        <= '0;
      n_q        <= '0;
      mk_q       <= '0;
      kn_q       <= '0;
      mn_q       <= '0;
      res_q      <= '0;
      mac_a_q    <= '0;
      mac_b_q    <= '0;
      size_err_q <= 1'b0;
    end else begin
      if (state_q == HDR) begin
        m_q  <= hdr_m;
        k_q  <= hdr_k;
        n_q  <= hdr_n;
        mk_q <= PW'(hdr_m) * PW'(hdr_k);
        kn_q <= PW'(hdr_k) * PW'(hdr_n);
        mn_q <= PW'(hdr_m) * PW'(hdr_n);
      end
      if (state_q == FETCH) begin
        mac_a_q <= din_a;
        mac_b_q <= din_b;
      end
      if (state_q == WAIT_RES && res_valid) begin
        res_q <= res_data;
      end
      if (state_q == IDLE && start) begin
        size_err_q <= 1'b0;
      end else if (err_set) begin
        size_err_q <= 1'b1;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign size_err  = size_err_q;
  assign we_b      = 1'b0;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_valid = (state_q == SEND);
  assign mac_last  = mac_valid && last_idx;

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: scoreboard bench with RAM and MAC models.
// Directed matrix cases, illegal headers, backpressure and reset.
module tb_matmul_sequencer;
  import matmul_pkg::*;

  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, size_err;
  logic [AW-1:0] addr_a, addr_b;
  logic          we_a, we_b;
  logic [DW-1:0] din_a, din_b, dout_a;
  logic [DW-1:0] mac_a, mac_b;
  logic          mac_valid, mac_last;
  logic          mac_ready;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [DW-1:0] acc;

  logic          toggle = 1'b0;
  logic [DW-1:0] mem [0:4095];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int stall_cnt = 0;
  int write_cnt = 0;
  int valid_cnt = 0;

  typedef struct packed {
    logic [AW-1:0] aa;
    logic [AW-1:0] ab;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          last;
  } pair_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  pair_t pq[$];
  wr_t   wq[$];
  logic  dq[$];

  matmul_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .size_err  (size_err),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .we_a      (we_a),
    .we_b      (we_b),
    .din_a     (din_a),
    .din_b     (din_b),
    .dout_a    (dout_a),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_valid (mac_valid),
    .mac_last  (mac_last),
    .mac_ready (mac_ready),
    .res_valid (res_valid),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    din_a <= mem[addr_a];
    din_b <= mem[addr_b];
  end

  always @(posedge clk)
    mac_ready <= toggle ? ~mac_ready : 1'b1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      res_valid <= 1'b0;
      if (mac_valid && mac_ready) begin
        if (mac_last) begin
          res_data  <= acc + mac_a * mac_b;
          res_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= acc + mac_a * mac_b;
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  logic          stall_prev = 1'b0;
  logic [DW-1:0] pa = '0;
  logic [DW-1:0] pb = '0;
  pair_t         ep;
  wr_t           ew;

  always @(negedge clk) begin
    if (reset) begin
      if (stall_prev)
        chk("stall_hold", 128'({mac_valid, mac_a, mac_b}),
            128'({1'b1, pa, pb}));
      stall_prev <= mac_valid && !mac_ready;
      pa <= mac_a;
      pb <= mac_b;
      if (mac_valid) valid_cnt <= valid_cnt + 1;
      if (mac_valid && !mac_ready) stall_cnt <= stall_cnt + 1;
      if (mac_valid && mac_ready) begin
        chk("pair_expected", 128'(pq.size() != 0), 128'(1));
        if (pq.size() != 0) begin
          ep = pq.pop_front();
          chk("pair", 128'({addr_a, addr_b, mac_a, mac_b,
                            mac_last}), 128'(ep));
        end
      end
      if (we_a) begin
        write_cnt <= write_cnt + 1;
        chk("write_expected", 128'(wq.size() != 0), 128'(1));
        if (wq.size() != 0) begin
          ew = wq.pop_front();
          chk("write", 128'({addr_a, dout_a}), 128'(ew));
        end
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
        chk("busy_at_done", 128'(busy), 128'(1));
        chk("done_expected", 128'(dq.size() != 0), 128'(1));
        if (dq.size() != 0)
          chk("size_err", 128'(size_err), 128'(dq.pop_front()));
      end
    end else begin
      stall_prev <= 1'b0;
    end
  end

  function automatic logic [127:0] outs();
    return 128'({busy, done, size_err, addr_a, addr_b, we_a,
                 we_b, dout_a, mac_a, mac_b, mac_valid,
                 mac_last});
  endfunction

  task automatic prep(input int m, input int k, input int n);
    int bb;
    bb = 1 + m * k;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++)
        for (int kk = 0; kk < k; kk++) begin
          pair_t p;
          p.aa = AW'(1 + i * k + kk);
          p.ab = AW'(bb + kk * n + j);
          p.a = mem[1 + i * k + kk];
          p.b = mem[bb + kk * n + j];
          p.last = (kk == k - 1);
          pq.push_back(p);
        end
    dq.push_back(1'b0);
  endtask

  task automatic start_run();
    @(negedge clk);
    #2 start = 1'b1;
    t0 = cyc;
    #1 chk("start_addr0", 128'(addr_a), 128'(0));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("done_seen", 128'(done_cnt - d0), 128'(1));
    #1 chk("idle_after", 128'({busy, done}), 128'(0));
  endtask

  task automatic run_ok(input int m, input int k, input int n,
                        input int lat, input int nwr);
    int d0, s0, w0;
    prep(m, k, n);
    d0 = done_cnt;
    s0 = stall_cnt;
    w0 = write_cnt;
    start_run();
    wait_done(d0);
    chk("latency", 128'(done_cyc - t0),
        128'(lat + stall_cnt - s0));
    chk("writes", 128'(write_cnt - w0), 128'(nwr));
    chk("queues_empty", 128'(pq.size() + wq.size() + dq.size()),
        128'(0));
  endtask

  task automatic run_err(input logic [DW-1:0] hdr);
    int d0, w0, v0;
    mem[0] = hdr;
    dq.push_back(1'b1);
    d0 = done_cnt;
    w0 = write_cnt;
    v0 = valid_cnt;
    start_run();
    wait_done(d0);
    chk("err_latency", 128'(done_cyc - t0), 128'(3));
    chk("err_writes", 128'(write_cnt - w0), 128'(0));
    chk("err_valids", 128'(valid_cnt - v0), 128'(0));
    repeat (2) @(posedge clk);
    #1 chk("err_held", 128'(size_err), 128'(1));
  endtask

  task automatic load222();
    mem[0] = 32'h0002_0202;
    for (int i = 0; i < 8; i++) mem[1 + i] = DW'(i + 1);
  endtask

  initial begin
    int d0, w0, n;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 128'(0));
    #2 reset = 1'b1;
    #1 chk("post_reset_outs", outs(), 128'(0));

    // 1x1x1: A at 1, B at 2, C at 3
    mem[0] = 32'h0001_0101;
    mem[1] = 3;
    mem[2] = 5;
    wq.push_back('{addr: 12'd3, data: 32'd15});
    run_ok(1, 1, 1, 8, 1);

    // 2x2x2: C at 9..12
    load222();
    wq.push_back('{addr: 12'd9,  data: 32'd19});
    wq.push_back('{addr: 12'd10, data: 32'd22});
    wq.push_back('{addr: 12'd11, data: 32'd43});
    wq.push_back('{addr: 12'd12, data: 32'd50});
    run_ok(2, 2, 2, 35, 4);

    // 2x3x1 with ready toggling: B at 7, C at 10
    mem[0] = 32'h0001_0302;
    for (int i = 0; i < 9; i++) mem[1 + i] = DW'(i + 1);
    wq.push_back('{addr: 12'd10, data: 32'd50});
    wq.push_back('{addr: 12'd11, data: 32'd122});
    toggle = 1'b1;
    n = stall_cnt;
    run_ok(2, 3, 1, 25, 2);
    chk("stalls_seen", 128'(stall_cnt > n), 128'(1));
    toggle = 1'b0;
    repeat (2) @(posedge clk);

    run_err(32'h0001_0001);
    run_err(32'h0001_0165);
    run_err(32'h0028_2828);

    // reset while a pair is being offered
    load222();
    prep(2, 2, 2);
    d0 = done_cnt;
    w0 = write_cnt;
    start_run();
    n = 0;
    while (!mac_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("reached_send", 128'(mac_valid), 128'(1));
    reset = 1'b0;
    #1 chk("rst_outs", outs(), 128'(0));
    chk("rst_state", 128'(dut.state_q), 128'(IDLE));
    @(negedge clk);
    #2 reset = 1'b1;
    pq.delete();
    wq.delete();
    dq.delete();
    repeat (5) @(posedge clk);
    #1 chk("rst_no_done", 128'(done_cnt - d0), 128'(0));
    chk("rst_no_write", 128'(write_cnt - w0), 128'(0));

    wq.push_back('{addr: 12'd9,  data: 32'd19});
    wq.push_back('{addr: 12'd10, data: 32'd22});
    wq.push_back('{addr: 12'd11, data: 32'd43});
    wq.push_back('{addr: 12'd12, data: 32'd50});
    run_ok(2, 2, 2, 35, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
